// File: rtl/intf_arb_pkg.sv
// Shared types and helpers for the round-robin write-channel arbiter.
package intf_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } arb_state_e;

   localparam int DEFAULT_DATA_W = 8;

   // Index width for a vector of n entries, never narrower than one bit.
   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req at or after start, wrapping.
module rr_picker
   import intf_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = owner_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   localparam int SUM_W = IDX_W + 1;

   logic [IDX_W-1:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] hit;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [SUM_W-1:0] sum;
         assign sum        = {1'b0, start} + SUM_W'(gi);
         assign cand[gi]   = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                       : sum[IDX_W-1:0];
         assign hit[gi]    = req[cand[gi]];
      end
   endgenerate

   // Walk from the far end so the closest hit to start wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/intf_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated write channel, with bounded bursts.
module intf_write_arbiter
   import intf_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int BURST_LEN = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        wr_en,
   output logic [DATA_W-1:0]           wr_data,
   input  logic                        wr_ready,
   output logic [$clog2(NUM_REQ)-1:0]  owner,
   output logic                        busy
);

   localparam int IDX_W = owner_w(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   arb_state_e       state_reg, state_next;
   logic [IDX_W-1:0] owner_reg, owner_next;
   logic [IDX_W-1:0] rr_start_reg, rr_start_next;
   logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic             tenure_valid_reg, tenure_valid_next;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             can_continue;
   logic             in_drive;

   logic [DATA_W-1:0] data_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (req),
      .start (rr_start_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign in_drive     = (state_reg == DRIVE);
   assign can_continue = tenure_valid_reg && req[owner_reg] &&
                         (beat_cnt_reg < CNT_W'(BURST_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         owner_reg        <= '0;
         rr_start_reg     <= '0;
         beat_cnt_reg     <= '0;
         tenure_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         owner_reg        <= owner_next;
         rr_start_reg     <= rr_start_next;
         beat_cnt_reg     <= beat_cnt_next;
         tenure_valid_reg <= tenure_valid_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      owner_next        = owner_reg;
      rr_start_next     = rr_start_reg;
      beat_cnt_next     = beat_cnt_reg;
      tenure_valid_next = tenure_valid_reg;
      case (state_reg)
         IDLE: begin
            if (enable && can_continue) begin
               state_next = DRIVE;
            end else if (enable && pick_found) begin
               // New tenure; the search for the next one starts just past this owner.
               state_next        = DRIVE;
               owner_next        = pick_idx;
               beat_cnt_next     = '0;
               tenure_valid_next = 1'b1;
               rr_start_next     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end else if (req == '0) begin
               tenure_valid_next = 1'b0;
            end
         end
         DRIVE: begin
            if (!req[owner_reg]) begin
               // Owner withdrew mid-beat: abandon the beat and the tenure.
               state_next        = IDLE;
               tenure_valid_next = 1'b0;
            end else if (wr_ready) begin
               state_next    = IDLE;
               beat_cnt_next = beat_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gnt     = '0;
      wr_data = '0;
      if (in_drive) begin
         wr_data        = data_arr[owner_reg];
         gnt[owner_reg] = req[owner_reg] && wr_ready;
      end
   end

   assign wr_en = in_drive;
   assign busy  = in_drive;
   assign owner = owner_reg;

endmodule
